char_pixel_renderer: RTL and testbench

CHAR_PIXEL_RENDERER -- requirements
Module: char_pixel_renderer

---
 rtl/char_pixel_renderer.sv | 174 +++++++++++++++++
 tb/tb_char_pixel_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/char_pixel_renderer.sv
// Text-mode pixel renderer: a small character buffer scanned by raster counters,
// two-stage pipeline turning glyph-array bits into a coloured pixel stream.
module char_pixel_renderer #(
  parameter int COLS        = 16,
  parameter int ROWS        = 4,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           line_start,
  input  logic                           pixel_en,
  input  logic                           wr_en,
  input  logic [$clog2(COLS*ROWS)-1:0]   wr_addr,
  input  logic [5:0]                     wr_data,
  input  logic [2:0]                     fg_rgb,
  input  logic [2:0]                     bg_rgb,
  input  logic [35:0]                    glyph_bits,
  output logic [1:0]                     x_out,
  output logic [2:0]                     y_out,
  output logic [2:0]                     rgb_out,
  output logic                           rgb_valid
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS + 1);
  localparam int RW    = $clog2(ROWS + 1);
  localparam int SW    = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_SHIFT) - 1);

  logic [5:0]    text_q [CELLS];

  logic [SW-1:0] hsub_q, hsub_d, hsub_cur;
  logic [2:0]    gc_q, gc_d, gc_cur;
  logic [CW-1:0] cc_q, cc_d, cc_cur;
  logic [SW-1:0] vsub_q, vsub_d;
  logic [2:0]    gr_q, gr_d;
  logic [RW-1:0] tr_q, tr_d;

  logic          s1_valid_q, blank_q;
  logic [5:0]    code_q;
  logic [1:0]    x_q;
  logic [2:0]    y_q;
  logic [2:0]    rgb_q;
  logic          valid_q;

  logic [AW-1:0] rd_idx;
  logic          in_range;
  logic [5:0]    rd_code;
  logic          blank_d;
  logic [63:0]   glyph_pad;
  logic          lit;

  // A line_start coinciding with pixel_en renders that pixel at column 0.
  always_comb begin
    hsub_cur = line_start ? '0 : hsub_q;
    gc_cur   = line_start ? 3'd0 : gc_q;
    cc_cur   = line_start ? '0 : cc_q;
    hsub_d   = hsub_cur;
    gc_d     = gc_cur;
    cc_d     = cc_cur;
    if (pixel_en) begin
      if (hsub_cur != SUB_MAX) begin
        hsub_d = hsub_cur + SW'(1);
      end else begin
        hsub_d = '0;
        if (gc_cur != 3'd4) begin
          gc_d = gc_cur + 3'd1;
        end else begin
          gc_d = 3'd0;
          if (cc_cur != CW'(COLS)) cc_d = cc_cur + CW'(1);
        end
      end
    end
  end

  // The vertical next state is also the row of any pixel rendered this cycle.
  always_comb begin
    vsub_d = vsub_q;
    gr_d   = gr_q;
    tr_d   = tr_q;
    if (frame_start) begin
      vsub_d = '0;
      gr_d   = 3'd0;
      tr_d   = '0;
    end else if (line_start) begin
      if (vsub_q != SUB_MAX) begin
        vsub_d = vsub_q + SW'(1);
      end else begin
        vsub_d = '0;
        if (gr_q != 3'd4) begin
          gr_d = gr_q + 3'd1;
        end else begin
          gr_d = 3'd0;
          if (tr_q != RW'(ROWS)) tr_d = tr_q + RW'(1);
        end
      end
    end
  end

  always_comb begin
    in_range = (tr_d < RW'(ROWS)) && (cc_cur < CW'(COLS));
    rd_idx   = AW'(tr_d) * AW'(COLS) + AW'(cc_cur);
    rd_code  = in_range ? text_q[rd_idx] : 6'h3f;
    blank_d  = (gc_cur == 3'd4) || (gr_d == 3'd4) || !in_range || (rd_code >= 6'd36);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hsub_q <= '0;
      gc_q   <= 3'd0;
      cc_q   <= '0;
      vsub_q <= '0;
      gr_q   <= 3'd0;
      tr_q   <= '0;
    end else begin
      hsub_q <= hsub_d;
      gc_q   <= gc_d;
      cc_q   <= cc_d;
      vsub_q <= vsub_d;
      gr_q   <= gr_d;
      tr_q   <= tr_d;
    end
  end

  // Out-of-range addresses match no cell, so those writes fall away.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) text_q[i] <= 6'h3f;
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) text_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      blank_q    <= 1'b0;
      code_q     <= 6'd0;
      x_q        <= 2'd0;
      y_q        <= 3'd0;
    end else begin
      s1_valid_q <= pixel_en;
      if (pixel_en) begin
        x_q     <= gc_cur[1:0];
        y_q     <= {1'b0, gr_d[1:0]};
        code_q  <= rd_code;
        blank_q <= blank_d;
      end
    end
  end

  assign glyph_pad = {28'd0, glyph_bits};
  assign lit       = !blank_q && glyph_pad[code_q];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      rgb_q   <= s1_valid_q ? (lit ? fg_rgb : bg_rgb) : 3'd0;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign rgb_out   = rgb_q;
  assign rgb_valid = valid_q;

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Directed bench: two renderer instances (unscaled 5x3 text, 8x-scaled 2x2 text)
// driven with shared raster timing and checked pixel by pixel.
module tb_char_pixel_renderer;

  localparam int C0 = 5, R0 = 3, C3 = 2, R3 = 2;
  localparam logic [2:0] FG = 3'b101, BG = 3'b010;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n = 1'b0, frame_start = 1'b0, line_start = 1'b0, pixel_en = 1'b0;
  logic        wr_en0 = 1'b0, wr_en3 = 1'b0;
  logic [3:0]  wr_addr0 = '0;
  logic [1:0]  wr_addr3 = '0;
  logic [5:0]  wr_data = '0;
  logic [2:0]  fg_rgb = FG, bg_rgb = BG;
  logic [35:0] glyph0, glyph3;
  logic [1:0]  x0, x3;
  logic [2:0]  y0, y3, rgb0, rgb3;
  logic        v0, v3;

  // Glyph array: code 0 lights column 0, code 1 lights row 1.
  assign glyph0 = {34'd0, (y0 == 3'd1), (x0 == 2'd0)};
  assign glyph3 = {34'd0, (y3 == 3'd1), (x3 == 2'd0)};

  char_pixel_renderer #(.COLS(C0), .ROWS(R0), .SCALE_SHIFT(0)) dut0 (
    .clock(clock), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .pixel_en(pixel_en), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .glyph_bits(glyph0),
    .x_out(x0), .y_out(y0), .rgb_out(rgb0), .rgb_valid(v0));

  char_pixel_renderer #(.COLS(C3), .ROWS(R3), .SCALE_SHIFT(3)) dut3 (
    .clock(clock), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .pixel_en(pixel_en), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .glyph_bits(glyph3),
    .x_out(x3), .y_out(y3), .rgb_out(rgb3), .rgb_valid(v3));

  int total = 0, bad = 0;
  int mem0 [C0*R0];
  int mem3 [C3*R3];
  int line_no = 0, fg0 = 0, fg3 = 0;
  int fg_hand [17] = '{5, 8, 4, 4, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};

  int q0[$], q3[$], xq0[$], xq3[$], yq0[$], yq3[$];
  logic pe_prev = 1'b0;

  always @(posedge clock) pe_prev <= pixel_en;

  always @(negedge clock) begin
    if (v0) q0.push_back(int'(rgb0));
    if (v3) q3.push_back(int'(rgb3));
    if (pe_prev) begin
      xq0.push_back(int'(x0)); xq3.push_back(int'(x3));
      yq0.push_back(int'(y0)); yq3.push_back(int'(y3));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] exp_pix(input bit d3, input int p, input int l);
    int sh, cols, rows, gc, cc, gr, tr, code;
    sh   = d3 ? 3 : 0;
    cols = d3 ? C3 : C0;
    rows = d3 ? R3 : R0;
    gc = (p >> sh) % 5; cc = (p >> sh) / 5;
    gr = (l >> sh) % 5; tr = (l >> sh) / 5;
    if (gc == 4 || gr == 4 || cc >= cols || tr >= rows) return BG;
    if (d3) code = mem3[tr*cols + cc];
    else    code = mem0[tr*cols + cc];
    if (code == 0 && gc == 0) return FG;
    if (code == 1 && gr == 1) return FG;
    return BG;
  endfunction

  task automatic wr0(input int a, input int d);
    wr_en0 = 1'b1; wr_addr0 = a[3:0]; wr_data = d[5:0];
    tick();
    wr_en0 = 1'b0;
    if (a < C0*R0) mem0[a] = d;
  endtask

  task automatic wr3(input int a, input int d);
    wr_en3 = 1'b1; wr_addr3 = a[1:0]; wr_data = d[5:0];
    tick();
    wr_en3 = 1'b0;
    if (a < C3*R3) mem3[a] = d;
  endtask

  // One raster line; optional write to dut0 during pixel wr_at.
  task automatic do_line(input bit fs, input int npix, input bit coincide, input bit chk_lat,
                         input int wr_at, input int wa, input int wd);
    logic [2:0] e0[$], e3[$];
    q0.delete(); q3.delete(); xq0.delete(); xq3.delete(); yq0.delete(); yq3.delete();
    if (fs) line_no = 0; else line_no++;
    if (!coincide) begin
      line_start = 1'b1; frame_start = fs;
      tick();
      line_start = 1'b0; frame_start = 1'b0;
    end
    for (int i = 0; i < npix; i++) begin
      pixel_en = 1'b1;
      if (coincide && i == 0) begin line_start = 1'b1; frame_start = fs; end
      e0.push_back(exp_pix(1'b0, i, line_no));
      e3.push_back(exp_pix(1'b1, i, line_no));
      if (i == wr_at) begin
        wr_en0 = 1'b1; wr_addr0 = wa[3:0]; wr_data = wd[5:0];
        mem0[wa] = wd;
      end
      tick();
      wr_en0 = 1'b0; line_start = 1'b0; frame_start = 1'b0;
      if (chk_lat && i < 2) chk($sformatf("latency_c%0d", i), v0, (i == 1) ? 1 : 0);
    end
    pixel_en = 1'b0;
    tick(); tick(); tick();
    chk("idle_valid", v0, 0);
    chk("idle_rgb", rgb0, 0);
    chk($sformatf("npix0_l%0d", line_no), q0.size(), npix);
    chk($sformatf("npix3_l%0d", line_no), q3.size(), npix);
    fg0 = 0; fg3 = 0;
    for (int i = 0; i < npix; i++) begin
      if (i < q0.size()) begin
        chk($sformatf("d0_l%0d_p%0d", line_no, i), q0[i], e0[i]);
        if (q0[i] == int'(FG)) fg0++;
      end
      if (i < q3.size()) begin
        chk($sformatf("d3_l%0d_p%0d", line_no, i), q3[i], e3[i]);
        if (q3[i] == int'(FG)) fg3++;
      end
    end
    if (yq0.size() > 0) chk($sformatf("y0_l%0d", line_no), yq0[0], (line_no % 5) & 3);
    if (yq3.size() > 0) chk($sformatf("y3_l%0d", line_no), yq3[0], ((line_no >> 3) % 5) & 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < C0*R0; i++) mem0[i] = 63;
    for (int i = 0; i < C3*R3; i++) mem3[i] = 63;

    // Reset state
    #12;
    chk("rst_valid0", v0, 0); chk("rst_rgb0", rgb0, 0);
    chk("rst_x0", x0, 0);     chk("rst_y0", y0, 0);
    chk("rst_valid3", v3, 0); chk("rst_x3", x3, 0);
    #10 rst_n = 1'b1;
    tick(); tick();

    // Blank buffer renders background only
    do_line(1'b1, 40, 1'b0, 1'b1, -1, 0, 0);
    chk("blank_fg0", fg0, 0);
    chk("blank_fg3", fg3, 0);

    // Single glyph in cell 0
    wr0(0, 0);
    wr3(0, 0);
    do_line(1'b1, 30, 1'b0, 1'b0, -1, 0, 0);
    chk("glyph_fg0", fg0, 1);
    if (q0.size() >= 2) begin
      chk("glyph_p0", q0[0], FG);
      chk("glyph_p1", q0[1], BG);
    end
    if (xq0.size() >= 5) begin
      chk("x_seq0", xq0[0], 0); chk("x_seq1", xq0[1], 1); chk("x_seq2", xq0[2], 2);
      chk("x_seq3", xq0[3], 3); chk("x_seq4", xq0[4], 0);
    end
    chk("scale_fg3", fg3, 8);
    if (xq3.size() >= 30) begin
      chk("sx_p7", xq3[7], 0);   chk("sx_p8", xq3[8], 1);
      chk("sx_p15", xq3[15], 1); chk("sx_p16", xq3[16], 2);
      chk("sx_p24", xq3[24], 3); chk("sx_p29", xq3[29], 3);
    end

    // Full frame: spacer rows, row/column saturation, out-of-range write, collision
    wr0(15, 1);
    for (int a = 1; a <= 5; a++) wr0(a, 0);
    wr0(10, 0);
    for (int l = 0; l < 17; l++) begin
      do_line(l == 0, 30, 1'b0, 1'b0, (l == 0) ? 5 : -1, 1, 1);
      chk($sformatf("fgcount_l%0d", l), fg0, fg_hand[l]);
    end

    // line_start together with the first pixel
    do_line(1'b1, 10, 1'b1, 1'b1, -1, 0, 0);
    chk("coinc_fg0", fg0, 1);
    chk("coinc_fg3", fg3, 8);
    if (xq0.size() >= 2) begin
      chk("coinc_x0", xq0[0], 0);
      chk("coinc_x1", xq0[1], 1);
    end

    // Reset in the middle of a pixel burst
    line_start = 1'b1; frame_start = 1'b1;
    tick();
    line_start = 1'b0; frame_start = 1'b0; pixel_en = 1'b1;
    repeat (6) tick();
    chk("pre_rst_valid", v0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid0", v0, 0); chk("mid_rst_rgb0", rgb0, 0);
    chk("mid_rst_valid3", v3, 0); chk("mid_rst_x0", x0, 0);
    tick(); tick();
    pixel_en = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < C0*R0; i++) mem0[i] = 63;
    for (int i = 0; i < C3*R3; i++) mem3[i] = 63;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", i), v0, 0);
    end
    do_line(1'b1, 30, 1'b0, 1'b1, -1, 0, 0);
    chk("post_rst_fg0", fg0, 0);
    chk("post_rst_fg3", fg3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
